i3c_rstact_ctrl: RTL

System-clock controller that sequences the I3C Slave Reset (SRST) detector.
- Decodes RSTACT CCC requests and drives the 4-bit reset-action/clear bus into the detector.
- Synchronizes the detector's asynchronous reset outputs into clk and sequences peripheral-reset completion back into a clear pulse.
- Answers GET RSTACT with reset-recovery times. Sits beside the CCC decoder in the always-on domain.

---
 rtl/i3c_rstact_pkg.sv | 25 ++
 rtl/i3c_rstact_sync.sv | 32 +++
 rtl/i3c_rstact_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/i3c_rstact_pkg.sv
// i3c_rstact_pkg: shared constants and types for the I3C RSTACT controller.
//   - RACT_* : 3-bit reset-action codes driven to the SRST detector.
//   - DB_*   : RSTACT CCC defining-byte values that have a fixed meaning.
//   - rstact_state_e : controller FSM states.
package i3c_rstact_pkg;

  localparam logic [2:0] RACT_NONE = 3'd0;
  localparam logic [2:0] RACT_DEF  = 3'd1;
  localparam logic [2:0] RACT_FULL = 3'd2;
  localparam logic [2:0] RACT_CUST = 3'd3;

  localparam logic [7:0] DB_NONE       = 8'h00;
  localparam logic [7:0] DB_DEF        = 8'h01;
  localparam logic [7:0] DB_FULL       = 8'h02;
  localparam logic [7:0] DB_GET_PERIPH = 8'h81;
  localparam logic [7:0] DB_GET_SYS    = 8'h82;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST_SEEN,
    ST_WAIT_DONE,
    ST_CLEARING
  } rstact_state_e;

endpackage

// File: rtl/i3c_rstact_sync.sv
// i3c_rstact_sync: WIDTH-bit multi-stage flop synchronizer with synchronous
// active-high reset (all stages clear to 0).
//   clk  in          destination clock
//   rst  in          synchronous reset, active-high
//   d    in  WIDTH   asynchronous inputs
//   q    out WIDTH   synchronized outputs (STAGES cycles of latency)
module i3c_rstact_sync
  import i3c_rstact_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/i3c_rstact_ctrl.sv
// i3c_rstact_ctrl: always-on controller sequencing the I3C SRST detector.
// Decodes RSTACT CCCs into the action/clear bus, synchronizes the detector's
// reset outputs, sequences peripheral-reset completion into a clear pulse and
// answers GET RSTACT with recovery times.
// Optional feature (macro I3C_RSTACT_TIMEOUT_EN): WAIT_DONE watchdog that
// latches rst_timeout after TIMEOUT_CYCLES without periph_rst_done.
// Ports:
//   clk, RST (sync, active-high)
//   ccc_rstact_vld/get/db   RSTACT CCC strobe, GET/SET form, defining byte
//   bus_start, bus_stop     START / STOP pulses
//   deepest_sleep           masks clear and SET requests
//   det_rst_action/block/all  async detector outputs
//   periph_rst_done         peripheral reset completed (level)
//   rst_action_bus[3:0]     {clear, action code} to detector
//   rstact_get_data/vld     GET RSTACT response
//   periph_rst_req, sys_rst_req, cust_rst_req, rst_timeout
module i3c_rstact_ctrl
  import i3c_rstact_pkg::*;
#(
  parameter logic [7:0]  PERIPH_RST_TIME = 8'h01,
  parameter logic [7:0]  SYS_RST_TIME    = 8'h05,
  parameter int unsigned CLR_CYCLES      = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       ccc_rstact_vld,
  input  logic       ccc_rstact_get,
  input  logic [7:0] ccc_rstact_db,
  input  logic       bus_start,
  input  logic       bus_stop,
  input  logic       deepest_sleep,
  input  logic       det_rst_action,
  input  logic       det_rst_block,
  input  logic       det_rst_all,
  input  logic       periph_rst_done,
  output logic [3:0] rst_action_bus,
  output logic [7:0] rstact_get_data,
  output logic       rstact_get_vld,
  output logic       periph_rst_req,
  output logic       sys_rst_req,
  output logic       cust_rst_req,
  output logic       rst_timeout
);

  if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr
    $error("CLR_CYCLES must be in 1..15");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..3");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0] s_det;
  logic       s_act, s_blk, s_all;

  i3c_rstact_sync #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (RST),
    .d   ({det_rst_all, det_rst_block, det_rst_action}),
    .q   (s_det)
  );

  assign {s_all, s_blk, s_act} = s_det;

  rstact_state_e state;
  logic [2:0]    action;
  logic          clr;
  logic [3:0]    clr_cnt;
  logic          stopped;
  logic          rearm;    // s_act must go low before the next SRST is accepted

  logic       set_req, get_req;
  logic [2:0] set_code;
  logic [7:0] get_val;

  // Defining bytes 0x80..0xFF in SET form carry no action and are dropped.
  assign set_req = ccc_rstact_vld & ~ccc_rstact_get & ~deepest_sleep & ~ccc_rstact_db[7];
  assign get_req = ccc_rstact_vld & ccc_rstact_get;

  always_comb begin
    set_code = RACT_CUST;
    case (ccc_rstact_db)
      DB_NONE: set_code = RACT_NONE;
      DB_DEF:  set_code = RACT_DEF;
      DB_FULL: set_code = RACT_FULL;
      default: set_code = RACT_CUST;
    endcase
  end

  always_comb begin
    get_val = 8'h00;
    if (ccc_rstact_db == DB_GET_PERIPH)   get_val = PERIPH_RST_TIME;
    else if (ccc_rstact_db == DB_GET_SYS) get_val = SYS_RST_TIME;
  end

`ifdef I3C_RSTACT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign rst_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state           <= ST_IDLE;
      action          <= RACT_NONE;
      clr             <= 1'b0;
      clr_cnt         <= '0;
      stopped         <= 1'b0;
      rearm           <= 1'b0;
      rstact_get_data <= '0;
      rstact_get_vld  <= 1'b0;
      periph_rst_req  <= 1'b0;
      sys_rst_req     <= 1'b0;
      cust_rst_req    <= 1'b0;
`ifdef I3C_RSTACT_TIMEOUT_EN
      to_cnt          <= '0;
      rst_timeout     <= 1'b0;
`endif
    end else begin
      cust_rst_req   <= 1'b0;
      rstact_get_vld <= get_req;
      if (get_req) rstact_get_data <= get_val;
      if (s_all) sys_rst_req <= 1'b1;

      // A START consumes a pending STOP; a simultaneous STOP re-arms it.
      stopped <= bus_stop | (stopped & ~bus_start);

      // Action is only writable in IDLE; a SET beats the START-expiry.
      if (state == ST_IDLE) begin
        if (set_req)                  action <= set_code;
        else if (bus_start && stopped) action <= RACT_NONE;
      end

      if (rearm && !s_act) rearm <= 1'b0;

      if (s_all) begin
        // System reset owns everything from here; park without clearing.
        state <= ST_RST_SEEN;
        clr   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (s_act && !rearm) state <= ST_RST_SEEN;
          end
          ST_RST_SEEN: begin
            if (s_blk) begin
              periph_rst_req <= 1'b1;
              state          <= ST_WAIT_DONE;
`ifdef I3C_RSTACT_TIMEOUT_EN
              to_cnt         <= '0;
`endif
            end else begin
              if (action == RACT_CUST) cust_rst_req <= 1'b1;
              clr     <= 1'b1;
              clr_cnt <= '0;
              state   <= ST_CLEARING;
            end
          end
          ST_WAIT_DONE: begin
`ifdef I3C_RSTACT_TIMEOUT_EN
            if (!rst_timeout) begin
              if (periph_rst_done) begin
                periph_rst_req <= 1'b0;
                clr            <= 1'b1;
                clr_cnt        <= '0;
                state          <= ST_CLEARING;
              end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                rst_timeout <= 1'b1;
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end
`else
            if (periph_rst_done) begin
              periph_rst_req <= 1'b0;
              clr            <= 1'b1;
              clr_cnt        <= '0;
              state          <= ST_CLEARING;
            end
`endif
          end
          ST_CLEARING: begin
            if (clr_cnt == 4'(CLR_CYCLES - 1)) begin
              clr    <= 1'b0;
              action <= RACT_NONE;
              rearm  <= s_act;
              state  <= ST_IDLE;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rst_action_bus = {clr & ~deepest_sleep, action};

endmodule
